// File: rtl/vdma_axi4_pkg.sv
// Shared constants for the VDMA AXI4 read/write cores.
package vdma_axi4_pkg;

    localparam logic [1:0] AXI_BURST_INCR       = 2'b01;
    localparam logic [3:0] AXI_CACHE_BUFFERABLE = 4'b0001;
    localparam logic [2:0] AXI_PROT_DEFAULT     = 3'b000;

    // Bit positions inside the AXI4-Stream tuser field
    localparam int TUSER_FRAME_START = 0;

endpackage

// File: rtl/vdma_frame_scan.sv
// Horizontal/vertical down-counter over a frame, stepping 'step' beats per advance.
// Flags the last step of a line and the last step of the whole frame.
module vdma_frame_scan #(
    parameter int H_WIDTH = 12,
    parameter int V_WIDTH = 12
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               load,
    input  logic               advance,
    input  logic [H_WIDTH-1:0] width,
    input  logic [H_WIDTH-1:0] step,
    input  logic [V_WIDTH-1:0] height,
    output logic               h_last,
    output logic               v_last,
    output logic               frame_last
);

    logic [H_WIDTH-1:0] h_rem;
    logic [V_WIDTH-1:0] v_rem;

    assign h_last     = (h_rem == '0);
    assign v_last     = (v_rem == '0);
    assign frame_last = h_last && v_last;

    // h_rem counts beats still to come in the line after the current step
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            h_rem <= '0;
            v_rem <= '0;
        end else if (load) begin
            h_rem <= width - step;
            v_rem <= height - V_WIDTH'(1);
        end else if (advance) begin
            if (h_last) begin
                h_rem <= width - step;
                v_rem <= v_rem - V_WIDTH'(1);
            end else begin
                h_rem <= h_rem - step;
            end
        end
    end

endmodule

// File: rtl/vdma_axi4_to_axi4s_core.sv
// Read-side VDMA core: fetches a 2-D frame with AXI4 INCR bursts and
// streams it out as AXI4-Stream video (tuser = frame start, tlast = end of line).
module vdma_axi4_to_axi4s_core
    import vdma_axi4_pkg::*;
#(
    parameter int AXI4_ID_WIDTH    = 6,
    parameter int AXI4_ADDR_WIDTH  = 32,
    parameter int AXI4_LEN_WIDTH   = 8,
    parameter int AXI4_QOS_WIDTH   = 4,
    parameter int AXI4_DATA_SIZE   = 2,
    parameter int AXI4_DATA_WIDTH  = (8 << AXI4_DATA_SIZE),
    parameter int AXI4S_USER_WIDTH = 1,
    parameter int STRIDE_WIDTH     = 14,
    parameter int INDEX_WIDTH      = 8,
    parameter int H_WIDTH          = 12,
    parameter int V_WIDTH          = 12
) (
    input  logic                        aclk,
    input  logic                        areset,

    input  logic                        ctl_enable,
    input  logic                        ctl_update,
    output logic                        ctl_busy,
    output logic [INDEX_WIDTH-1:0]      ctl_index,

    input  logic [AXI4_ADDR_WIDTH-1:0]  param_addr,
    input  logic [STRIDE_WIDTH-1:0]     param_stride,
    input  logic [H_WIDTH-1:0]          param_width,
    input  logic [V_WIDTH-1:0]          param_height,
    input  logic [AXI4_LEN_WIDTH-1:0]   param_arlen,

    output logic [AXI4_ADDR_WIDTH-1:0]  monitor_addr,
    output logic [STRIDE_WIDTH-1:0]     monitor_stride,
    output logic [H_WIDTH-1:0]          monitor_width,
    output logic [V_WIDTH-1:0]          monitor_height,
    output logic [AXI4_LEN_WIDTH-1:0]   monitor_arlen,

    output logic [AXI4_ID_WIDTH-1:0]    m_axi4_arid,
    output logic [AXI4_ADDR_WIDTH-1:0]  m_axi4_araddr,
    output logic [1:0]                  m_axi4_arburst,
    output logic [3:0]                  m_axi4_arcache,
    output logic [AXI4_LEN_WIDTH-1:0]   m_axi4_arlen,
    output logic                        m_axi4_arlock,
    output logic [2:0]                  m_axi4_arprot,
    output logic [AXI4_QOS_WIDTH-1:0]   m_axi4_arqos,
    output logic [3:0]                  m_axi4_arregion,
    output logic [2:0]                  m_axi4_arsize,
    output logic                        m_axi4_arvalid,
    input  logic                        m_axi4_arready,

    input  logic [AXI4_ID_WIDTH-1:0]    m_axi4_rid,
    input  logic [1:0]                  m_axi4_rresp,
    input  logic [AXI4_DATA_WIDTH-1:0]  m_axi4_rdata,
    input  logic                        m_axi4_rlast,
    input  logic                        m_axi4_rvalid,
    output logic                        m_axi4_rready,

    output logic [AXI4S_USER_WIDTH-1:0] m_axi4s_tuser,
    output logic                        m_axi4s_tlast,
    output logic [AXI4_DATA_WIDTH-1:0]  m_axi4s_tdata,
    output logic                        m_axi4s_tvalid,
    input  logic                        m_axi4s_tready
);

    logic [AXI4_ADDR_WIDTH-1:0] shadow_addr;
    logic [STRIDE_WIDTH-1:0]    shadow_stride;
    logic [H_WIDTH-1:0]         shadow_width;
    logic [V_WIDTH-1:0]         shadow_height;
    logic [AXI4_LEN_WIDTH-1:0]  shadow_arlen;

    logic                       r_busy;
    logic                       r_first;
    logic [AXI4_ADDR_WIDTH-1:0] line_base;

    logic                       boundary;
    logic                       frame_start;
    logic                       load_params;
    logic                       ar_hs;
    logic                       r_hs;

    logic [AXI4_ADDR_WIDTH-1:0] cfg_addr;
    logic [H_WIDTH-1:0]         cfg_width;
    logic [V_WIDTH-1:0]         cfg_height;
    logic [AXI4_LEN_WIDTH-1:0]  cfg_arlen;
    logic [H_WIDTH-1:0]         cfg_step;
    logic [AXI4_ADDR_WIDTH-1:0] burst_bytes;
    logic [AXI4_ADDR_WIDTH-1:0] next_line;

    logic ar_h_last, ar_v_last, ar_frame_last;
    logic r_h_last, r_v_last, r_frame_last;
    logic unused_r_sideband;

    // rid/rresp/rlast are not needed: framing comes from the internal counters
    assign unused_r_sideband = ^{m_axi4_rid, m_axi4_rresp, m_axi4_rlast, ar_v_last, r_v_last};

    assign boundary    = !ctl_busy || (!m_axi4_arvalid && !r_busy);
    assign frame_start = boundary && ctl_enable;
    assign load_params = frame_start && ctl_update;

    // Parameters of the frame about to start are visible the same cycle they are latched
    assign cfg_addr    = load_params ? param_addr   : shadow_addr;
    assign cfg_width   = load_params ? param_width  : shadow_width;
    assign cfg_height  = load_params ? param_height : shadow_height;
    assign cfg_arlen   = load_params ? param_arlen  : shadow_arlen;
    assign cfg_step    = H_WIDTH'(cfg_arlen) + H_WIDTH'(1);

    assign burst_bytes = (AXI4_ADDR_WIDTH'(shadow_arlen) + AXI4_ADDR_WIDTH'(1)) << AXI4_DATA_SIZE;
    assign next_line   = line_base + AXI4_ADDR_WIDTH'(shadow_stride);

    assign ar_hs         = m_axi4_arvalid && m_axi4_arready;
    assign r_hs          = m_axi4_rvalid && m_axi4_rready;
    assign m_axi4_rready = r_busy && (!m_axi4s_tvalid || m_axi4s_tready);

    assign m_axi4_arid     = '0;
    assign m_axi4_arburst  = AXI_BURST_INCR;
    assign m_axi4_arcache  = AXI_CACHE_BUFFERABLE;
    assign m_axi4_arlen    = shadow_arlen;
    assign m_axi4_arlock   = 1'b0;
    assign m_axi4_arprot   = AXI_PROT_DEFAULT;
    assign m_axi4_arqos    = '0;
    assign m_axi4_arregion = 4'b0000;
    assign m_axi4_arsize   = 3'(AXI4_DATA_SIZE);

    assign monitor_addr   = shadow_addr;
    assign monitor_stride = shadow_stride;
    assign monitor_width  = shadow_width;
    assign monitor_height = shadow_height;
    assign monitor_arlen  = shadow_arlen;

    vdma_frame_scan #(.H_WIDTH(H_WIDTH), .V_WIDTH(V_WIDTH)) u_ar_scan (
        .aclk       (aclk),
        .areset     (areset),
        .load       (frame_start),
        .advance    (ar_hs),
        .width      (cfg_width),
        .step       (cfg_step),
        .height     (cfg_height),
        .h_last     (ar_h_last),
        .v_last     (ar_v_last),
        .frame_last (ar_frame_last)
    );

    vdma_frame_scan #(.H_WIDTH(H_WIDTH), .V_WIDTH(V_WIDTH)) u_r_scan (
        .aclk       (aclk),
        .areset     (areset),
        .load       (frame_start),
        .advance    (r_hs),
        .width      (cfg_width),
        .step       (H_WIDTH'(1)),
        .height     (cfg_height),
        .h_last     (r_h_last),
        .v_last     (r_v_last),
        .frame_last (r_frame_last)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ctl_busy      <= 1'b0;
            ctl_index     <= '0;
            shadow_addr   <= '0;
            shadow_stride <= '0;
            shadow_width  <= '0;
            shadow_height <= '0;
            shadow_arlen  <= '0;
        end else if (boundary) begin
            ctl_busy <= ctl_enable;
            if (ctl_enable) begin
                ctl_index <= ctl_index + INDEX_WIDTH'(1);
            end
            if (load_params) begin
                shadow_addr   <= param_addr;
                shadow_stride <= param_stride;
                shadow_width  <= param_width;
                shadow_height <= param_height;
                shadow_arlen  <= param_arlen;
            end
        end
    end

    // Address side runs ahead of the data side; it only waits on arready
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_axi4_arvalid <= 1'b0;
            m_axi4_araddr  <= '0;
            line_base      <= '0;
        end else if (frame_start) begin
            m_axi4_arvalid <= 1'b1;
            m_axi4_araddr  <= cfg_addr;
            line_base      <= cfg_addr;
        end else if (ar_hs) begin
            if (ar_frame_last) begin
                m_axi4_arvalid <= 1'b0;
            end else if (ar_h_last) begin
                m_axi4_araddr <= next_line;
                line_base     <= next_line;
            end else begin
                m_axi4_araddr <= m_axi4_araddr + burst_bytes;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_busy         <= 1'b0;
            r_first        <= 1'b0;
            m_axi4s_tvalid <= 1'b0;
            m_axi4s_tuser  <= '0;
            m_axi4s_tlast  <= 1'b0;
            m_axi4s_tdata  <= '0;
        end else begin
            if (frame_start) begin
                r_busy  <= 1'b1;
                r_first <= 1'b1;
            end else if (r_hs) begin
                r_first <= 1'b0;
                if (r_frame_last) begin
                    r_busy <= 1'b0;
                end
            end

            if (r_hs) begin
                m_axi4s_tvalid <= 1'b1;
                m_axi4s_tdata  <= m_axi4_rdata;
                m_axi4s_tuser  <= AXI4S_USER_WIDTH'(r_first) << TUSER_FRAME_START;
                m_axi4s_tlast  <= r_h_last;
            end else if (m_axi4s_tready) begin
                m_axi4s_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vdma_axi4_to_axi4s_core.sv
// Directed bench for the read-side VDMA core with an in-bench AXI4 memory slave
// and a scoreboard of expected AR requests and stream beats.
module tb_vdma_axi4_to_axi4s_core;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BYTES_PER_BEAT = 4;

    logic          aclk = 1'b0;
    logic          areset;
    logic          ctl_enable, ctl_update, ctl_busy;
    logic [7:0]    ctl_index;
    logic [AW-1:0] param_addr;
    logic [13:0]   param_stride;
    logic [11:0]   param_width, param_height;
    logic [7:0]    param_arlen;
    logic [AW-1:0] monitor_addr;
    logic [13:0]   monitor_stride;
    logic [11:0]   monitor_width, monitor_height;
    logic [7:0]    monitor_arlen;
    logic [5:0]    m_axi4_arid, m_axi4_rid;
    logic [AW-1:0] m_axi4_araddr;
    logic [1:0]    m_axi4_arburst, m_axi4_rresp;
    logic [3:0]    m_axi4_arcache, m_axi4_arqos, m_axi4_arregion;
    logic [7:0]    m_axi4_arlen;
    logic          m_axi4_arlock, m_axi4_arvalid, m_axi4_arready;
    logic [2:0]    m_axi4_arprot, m_axi4_arsize;
    logic [DW-1:0] m_axi4_rdata, m_axi4s_tdata;
    logic          m_axi4_rlast, m_axi4_rvalid, m_axi4_rready;
    logic [0:0]    m_axi4s_tuser;
    logic          m_axi4s_tlast, m_axi4s_tvalid, m_axi4s_tready;

    always #5 aclk = ~aclk;

    vdma_axi4_to_axi4s_core dut (
        .aclk(aclk), .areset(areset),
        .ctl_enable(ctl_enable), .ctl_update(ctl_update), .ctl_busy(ctl_busy), .ctl_index(ctl_index),
        .param_addr(param_addr), .param_stride(param_stride), .param_width(param_width),
        .param_height(param_height), .param_arlen(param_arlen),
        .monitor_addr(monitor_addr), .monitor_stride(monitor_stride), .monitor_width(monitor_width),
        .monitor_height(monitor_height), .monitor_arlen(monitor_arlen),
        .m_axi4_arid(m_axi4_arid), .m_axi4_araddr(m_axi4_araddr), .m_axi4_arburst(m_axi4_arburst),
        .m_axi4_arcache(m_axi4_arcache), .m_axi4_arlen(m_axi4_arlen), .m_axi4_arlock(m_axi4_arlock),
        .m_axi4_arprot(m_axi4_arprot), .m_axi4_arqos(m_axi4_arqos), .m_axi4_arregion(m_axi4_arregion),
        .m_axi4_arsize(m_axi4_arsize), .m_axi4_arvalid(m_axi4_arvalid), .m_axi4_arready(m_axi4_arready),
        .m_axi4_rid(m_axi4_rid), .m_axi4_rresp(m_axi4_rresp), .m_axi4_rdata(m_axi4_rdata),
        .m_axi4_rlast(m_axi4_rlast), .m_axi4_rvalid(m_axi4_rvalid), .m_axi4_rready(m_axi4_rready),
        .m_axi4s_tuser(m_axi4s_tuser), .m_axi4s_tlast(m_axi4s_tlast), .m_axi4s_tdata(m_axi4s_tdata),
        .m_axi4s_tvalid(m_axi4s_tvalid), .m_axi4s_tready(m_axi4s_tready)
    );

    int checks = 0;
    int failures = 0;

    logic [AW+7:0] exp_ar[$];     // {arlen, araddr}
    logic [DW+1:0] exp_beat[$];   // {tuser, tlast, tdata}
    logic [AW+7:0] bursts[$];     // accepted bursts awaiting data
    int r_beat = 0;
    bit gaps = 1'b0;
    bit rand_tready = 1'b0;
    bit ar_stall = 1'b0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Program the parameters and push the whole expected frame onto the scoreboard
    task automatic applyStimulus(input logic [AW-1:0] a, input logic [13:0] s,
                                 input logic [11:0] w, input logic [11:0] h, input logic [7:0] l);
        logic [AW-1:0] lb;
        int per_line;
        param_addr   = a;
        param_stride = s;
        param_width  = w;
        param_height = h;
        param_arlen  = l;
        per_line = int'(w) / (int'(l) + 1);
        for (int v = 0; v < int'(h); v++) begin
            lb = a + 32'(v) * 32'(s);
            for (int bb = 0; bb < per_line; bb++)
                exp_ar.push_back({l, lb + 32'(bb * (int'(l) + 1) * BYTES_PER_BEAT)});
            for (int b = 0; b < int'(w); b++)
                exp_beat.push_back({(v == 0 && b == 0), (b == int'(w) - 1),
                                    mem_word(lb + 32'(b * BYTES_PER_BEAT))});
        end
    endtask

    task automatic enableFrame(input bit upd);
        @(posedge aclk); #1;
        ctl_enable = 1'b1;
        ctl_update = upd;
    endtask

    task automatic dropEnable();
        @(posedge aclk); #1;
        ctl_enable = 1'b0;
        ctl_update = 1'b0;
    endtask

    task automatic waitBusy(input string tag);
        int n = 0;
        while (!ctl_busy && n < 50) begin @(negedge aclk); n++; end
        checkOutput(tag, 64'(ctl_busy), 64'(1));
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n = 0;
        while ((ctl_busy || exp_beat.size() != 0 || exp_ar.size() != 0) && n < budget) begin
            @(negedge aclk); n++;
        end
        checkOutput(tag, 64'(n < budget), 64'(1));
    endtask

    task automatic waitIndex(input string tag, input logic [7:0] target, output bit gap_seen);
        int n = 0;
        gap_seen = 1'b0;
        while (ctl_index != target && n < 500) begin
            @(negedge aclk); n++;
            if (!ctl_busy) gap_seen = 1'b1;
        end
        checkOutput(tag, 64'(ctl_index), 64'(target));
    endtask

    // AXI4 memory slave plus stream monitor
    initial begin : slave
        logic ar_hs, r_hs, t_hs;
        logic [AW+7:0] bu;
        forever begin
            @(negedge aclk);
            ar_hs = m_axi4_arvalid && m_axi4_arready;
            r_hs  = m_axi4_rvalid && m_axi4_rready;
            t_hs  = m_axi4s_tvalid && m_axi4s_tready;
            if (ar_hs) begin
                checkOutput("ar_expected", 64'(exp_ar.size() != 0), 64'(1));
                if (exp_ar.size() != 0)
                    checkOutput("ar_request", 64'({m_axi4_arlen, m_axi4_araddr}), 64'(exp_ar.pop_front()));
                bursts.push_back({m_axi4_arlen, m_axi4_araddr});
            end
            if (t_hs) begin
                checkOutput("beat_expected", 64'(exp_beat.size() != 0), 64'(1));
                if (exp_beat.size() != 0)
                    checkOutput("stream_beat", 64'({m_axi4s_tuser[0], m_axi4s_tlast, m_axi4s_tdata}),
                                64'(exp_beat.pop_front()));
            end
            if (m_axi4s_tvalid && !m_axi4s_tready)
                checkOutput("rready_backpressure", 64'(m_axi4_rready), 64'(0));
            @(posedge aclk); #1;
            if (r_hs && bursts.size() != 0) begin
                r_beat++;
                if (r_beat > int'(bursts[0][AW+7:AW])) begin
                    void'(bursts.pop_front());
                    r_beat = 0;
                end
            end
            if (!(m_axi4_rvalid && !r_hs)) begin
                if (bursts.size() != 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
                    bu = bursts[0];
                    m_axi4_rvalid = 1'b1;
                    m_axi4_rdata  = mem_word(bu[AW-1:0] + 32'(r_beat * BYTES_PER_BEAT));
                    m_axi4_rlast  = (r_beat == int'(bu[AW+7:AW]));
                end else begin
                    m_axi4_rvalid = 1'b0;
                end
            end
            m_axi4_arready = ar_stall ? 1'b0 : (gaps ? 1'($urandom_range(0, 1)) : 1'b1);
            m_axi4s_tready = rand_tready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : main
        bit gap_seen;
        bit stable;
        logic [AW-1:0] a0;
        logic [7:0] l0;
        int size_before;
        int n;

        areset = 1'b1;
        ctl_enable = 1'b0; ctl_update = 1'b0;
        param_addr = '0; param_stride = '0; param_width = '0; param_height = '0; param_arlen = '0;
        m_axi4_arready = 1'b0; m_axi4_rvalid = 1'b0; m_axi4_rdata = '0;
        m_axi4_rid = '0; m_axi4_rresp = '0; m_axi4_rlast = 1'b0; m_axi4s_tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        checkOutput("reset_busy",   64'(ctl_busy), 64'(0));
        checkOutput("reset_index",  64'(ctl_index), 64'(0));
        checkOutput("reset_arvalid", 64'(m_axi4_arvalid), 64'(0));
        checkOutput("reset_tvalid", 64'(m_axi4s_tvalid), 64'(0));
        checkOutput("reset_tuser",  64'(m_axi4s_tuser), 64'(0));
        checkOutput("reset_tlast",  64'(m_axi4s_tlast), 64'(0));
        checkOutput("reset_monitor_addr", 64'(monitor_addr), 64'(0));
        checkOutput("arburst_incr", 64'(m_axi4_arburst), 64'(1));
        checkOutput("arsize", 64'(m_axi4_arsize), 64'(2));
        checkOutput("arcache", 64'(m_axi4_arcache), 64'(1));
        areset = 1'b0;

        $display("[TB] basic 8x2 frame, arlen=3");
        applyStimulus(32'h1000, 14'h100, 12'd8, 12'd2, 8'd3);
        enableFrame(1'b1);
        waitBusy("frame_a_busy");
        dropEnable();
        checkOutput("frame_a_index", 64'(ctl_index), 64'(1));
        waitIdle("frame_a_done", 500);
        checkOutput("frame_a_monitor_addr", 64'(monitor_addr), 64'(32'h1000));
        checkOutput("frame_a_monitor_width", 64'(monitor_width), 64'(8));
        checkOutput("frame_a_arvalid_off", 64'(m_axi4_arvalid), 64'(0));

        $display("[TB] random tready and rvalid gaps");
        gaps = 1'b1; rand_tready = 1'b1;
        applyStimulus(32'h2000, 14'h80, 12'd16, 12'd3, 8'd3);
        enableFrame(1'b1);
        waitBusy("frame_b_busy");
        dropEnable();
        waitIdle("frame_b_done", 4000);
        gaps = 1'b0; rand_tready = 1'b0;
        checkOutput("frame_b_index", 64'(ctl_index), 64'(2));

        $display("[TB] 1x1 frames back to back");
        applyStimulus(32'h3000, 14'h4, 12'd1, 12'd1, 8'd0);
        applyStimulus(32'h3000, 14'h4, 12'd1, 12'd1, 8'd0);
        enableFrame(1'b1);
        waitBusy("tiny_busy");
        waitIndex("tiny_index", 8'd4, gap_seen);
        dropEnable();
        checkOutput("tiny_no_gap", 64'(gap_seen), 64'(0));
        waitIdle("tiny_done", 500);

        $display("[TB] update mid-frame");
        applyStimulus(32'h4000, 14'h40, 12'd8, 12'd2, 8'd1);
        enableFrame(1'b1);
        waitBusy("upd_busy");
        applyStimulus(32'h5000, 14'h40, 12'd8, 12'd2, 8'd1);
        waitIndex("upd_index", 8'd6, gap_seen);
        dropEnable();
        checkOutput("upd_no_gap", 64'(gap_seen), 64'(0));
        n = 0;
        while (ctl_busy && n < 500) begin @(negedge aclk); n++; end
        checkOutput("upd_busy_fall", 64'(ctl_busy), 64'(0));
        checkOutput("busy_after_last_beat", 64'(exp_beat.size()), 64'(0));
        waitIdle("upd_done", 200);
        checkOutput("upd_monitor_addr", 64'(monitor_addr), 64'(32'h5000));

        $display("[TB] arready held low");
        ar_stall = 1'b1;
        applyStimulus(32'h7000, 14'h200, 12'd8, 12'd2, 8'd3);
        enableFrame(1'b1);
        waitBusy("stall_busy");
        dropEnable();
        @(negedge aclk);
        a0 = m_axi4_araddr;
        l0 = m_axi4_arlen;
        checkOutput("stall_first_addr", 64'(a0), 64'(32'h7000));
        size_before = exp_beat.size();
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (!(m_axi4_arvalid && m_axi4_araddr == a0 && m_axi4_arlen == l0)) stable = 1'b0;
        end
        checkOutput("stall_ar_stable", 64'(stable), 64'(1));
        checkOutput("stall_no_output", 64'(exp_beat.size()), 64'(size_before));
        ar_stall = 1'b0;
        waitIdle("stall_done", 500);

        $display("[TB] reset mid-frame");
        applyStimulus(32'h6000, 14'h100, 12'd16, 12'd4, 8'd3);
        enableFrame(1'b1);
        waitBusy("rst_busy");
        dropEnable();
        n = 0;
        while (exp_beat.size() > 58 && n < 200) begin @(negedge aclk); n++; end
        checkOutput("rst_streaming", 64'(exp_beat.size() <= 58), 64'(1));
        @(posedge aclk); #2;
        areset = 1'b1;
        #1;
        checkOutput("rst_arvalid", 64'(m_axi4_arvalid), 64'(0));
        checkOutput("rst_tvalid",  64'(m_axi4s_tvalid), 64'(0));
        checkOutput("rst_busy_low", 64'(ctl_busy), 64'(0));
        checkOutput("rst_index",   64'(ctl_index), 64'(0));
        exp_ar.delete();
        exp_beat.delete();
        bursts.delete();
        r_beat = 0;
        m_axi4_rvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #3;
        areset = 1'b0;
        applyStimulus(32'h6000, 14'h100, 12'd16, 12'd2, 8'd3);
        enableFrame(1'b1);
        waitBusy("restart_busy");
        dropEnable();
        checkOutput("restart_index", 64'(ctl_index), 64'(1));
        waitIdle("restart_done", 500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
